// File: rtl/stage_wb_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | stage_wb_if : memory-access -> write-back stage bus                        |
// | Optional macro: PERF_CNT_EN adds the performance counter signals.          |
// | Revision: 1.0 - initial release                                            |
// +----------------------------------------------------------------------------+
interface stage_wb_if;
    logic [31:0] PC_I;
    logic        Done_I;
    logic [31:0] RWD_I;
    logic [4:0]  RAR_I;
    logic [2:0]  Funct3;
    logic        Is_Load;
    logic [1:0]  Addr_Lo;
    logic        RF_wen;
    logic [4:0]  RF_waddr;
    logic [31:0] RF_wdata;
    logic [31:0] PC_O;
    logic        Done_O;
    logic        Feedback_WB_Busy;
`ifdef PERF_CNT_EN
    logic [31:0] Cycle_Cnt;
    logic [31:0] Inst_Cnt;
    logic [31:0] Load_Cnt;

    modport master (
        output PC_I, Done_I, RWD_I, RAR_I, Funct3, Is_Load, Addr_Lo,
        input  RF_wen, RF_waddr, RF_wdata, PC_O, Done_O, Feedback_WB_Busy,
        input  Cycle_Cnt, Inst_Cnt, Load_Cnt
    );
    modport slave (
        input  PC_I, Done_I, RWD_I, RAR_I, Funct3, Is_Load, Addr_Lo,
        output RF_wen, RF_waddr, RF_wdata, PC_O, Done_O, Feedback_WB_Busy,
        output Cycle_Cnt, Inst_Cnt, Load_Cnt
    );
`else
    modport master (
        output PC_I, Done_I, RWD_I, RAR_I, Funct3, Is_Load, Addr_Lo,
        input  RF_wen, RF_waddr, RF_wdata, PC_O, Done_O, Feedback_WB_Busy
    );
    modport slave (
        input  PC_I, Done_I, RWD_I, RAR_I, Funct3, Is_Load, Addr_Lo,
        output RF_wen, RF_waddr, RF_wdata, PC_O, Done_O, Feedback_WB_Busy
    );
`endif
endinterface
`default_nettype wire

// File: rtl/stage_wb.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | stage_wb : write-back stage, load data extraction and register-file write  |
// | Optional macro: PERF_CNT_EN enables cycle/instruction/load counters.       |
// | Revision: 1.0 - initial release                                            |
// +----------------------------------------------------------------------------+
module stage_wb (
    input  wire        clk,
    input  wire        rst,
    stage_wb_if.slave  bus
);
    typedef enum logic [0:0] {
        s_IDLE = 1'b0,
        s_WB   = 1'b1
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;
    logic        r_armed;
    logic        r_rf_wen;
    logic [4:0]  r_waddr;
    logic [31:0] r_wdata;
    logic [31:0] r_pc;
    logic        w_done_in;
    logic [7:0]  w_byte;
    logic [15:0] w_half;
    logic [31:0] w_load;
    logic [31:0] w_wdata;

    // The first edge after reset release is not trusted to carry an instruction.
    assign w_done_in = bus.Done_I & r_armed;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= s_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = s_IDLE;
        case (r_state)
            s_IDLE:  w_state_nxt = w_done_in ? s_WB : s_IDLE;
            s_WB:    w_state_nxt = w_done_in ? s_WB : s_IDLE;
            default: w_state_nxt = s_IDLE;
        endcase
    end

    always_comb begin
        w_byte = bus.RWD_I[7:0];
        case (bus.Addr_Lo)
            2'd0:    w_byte = bus.RWD_I[7:0];
            2'd1:    w_byte = bus.RWD_I[15:8];
            2'd2:    w_byte = bus.RWD_I[23:16];
            default: w_byte = bus.RWD_I[31:24];
        endcase
        // Misaligned halves fall back to the half selected by Addr_Lo[1].
        w_half = bus.Addr_Lo[1] ? bus.RWD_I[31:16] : bus.RWD_I[15:0];
        w_load = bus.RWD_I;
        case (bus.Funct3)
            3'b000:  w_load = {{24{w_byte[7]}}, w_byte};
            3'b001:  w_load = {{16{w_half[15]}}, w_half};
            3'b010:  w_load = bus.RWD_I;
            3'b100:  w_load = {24'd0, w_byte};
            3'b101:  w_load = {16'd0, w_half};
            default: w_load = bus.RWD_I;
        endcase
        w_wdata = bus.Is_Load ? w_load : bus.RWD_I;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_armed  <= 1'b0;
            r_rf_wen <= 1'b0;
            r_waddr  <= 5'd0;
            r_wdata  <= 32'd0;
            r_pc     <= 32'd0;
        end else begin
            r_armed  <= 1'b1;
            r_rf_wen <= w_done_in && (bus.RAR_I != 5'd0);
            if (w_done_in) begin
                r_waddr <= bus.RAR_I;
                r_wdata <= w_wdata;
                r_pc    <= bus.PC_I;
            end
        end
    end

    assign bus.Done_O           = (r_state == s_WB);
    assign bus.RF_wen           = r_rf_wen;
    assign bus.RF_waddr         = r_waddr;
    assign bus.RF_wdata         = r_wdata;
    assign bus.PC_O             = r_pc;
    assign bus.Feedback_WB_Busy = r_rf_wen;

`ifdef PERF_CNT_EN
    logic [31:0] r_cycle_cnt;
    logic [31:0] r_inst_cnt;
    logic [31:0] r_load_cnt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_cycle_cnt <= 32'd0;
            r_inst_cnt  <= 32'd0;
            r_load_cnt  <= 32'd0;
        end else begin
            r_cycle_cnt <= r_cycle_cnt + 32'd1;
            if (w_done_in) begin
                r_inst_cnt <= r_inst_cnt + 32'd1;
            end
            if (w_done_in && bus.Is_Load) begin
                r_load_cnt <= r_load_cnt + 32'd1;
            end
        end
    end

    assign bus.Cycle_Cnt = r_cycle_cnt;
    assign bus.Inst_Cnt  = r_inst_cnt;
    assign bus.Load_Cnt  = r_load_cnt;
`endif
endmodule
`default_nettype wire

// File: tb/tb_stage_wb.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_stage_wb : randomized + directed bench for stage_wb against a model     |
// | Revision: 1.0 - initial release                                            |
// +----------------------------------------------------------------------------+
module tb_stage_wb;
    logic clk = 1'b0;
    logic rst = 1'b0;
    int   checks   = 0;
    int   failures = 0;

    stage_wb_if bus ();

    stage_wb dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    // Architectural result of a retiring instruction, from the ISA rules.
    function automatic logic [31:0] ref_data(input logic [31:0] w, input logic [2:0] f3,
                                             input logic ld, input logic [1:0] lo);
        logic [31:0] b;
        logic [31:0] h;
        b = (w >> (8 * lo)) & 32'h0000_00FF;
        h = (w >> (16 * lo[1])) & 32'h0000_FFFF;
        if (!ld) return w;
        case (f3)
            3'b000:  return (b ^ 32'h80) - 32'h80;
            3'b001:  return (h ^ 32'h8000) - 32'h8000;
            3'b100:  return b;
            3'b101:  return h;
            default: return w;
        endcase
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%08h expected=%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: what the stage must show after each edge.
    logic        m_live, m_done, m_wen;
    logic [4:0]  m_waddr;
    logic [31:0] m_wdata, m_pc;

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_live <= 1'b0; m_done <= 1'b0; m_wen <= 1'b0;
            m_waddr <= 5'd0; m_wdata <= 32'd0; m_pc <= 32'd0;
        end else begin
            m_live <= 1'b1;
            m_done <= bus.Done_I && m_live;
            m_wen  <= bus.Done_I && m_live && (bus.RAR_I != 5'd0);
            if (bus.Done_I && m_live) begin
                m_waddr <= bus.RAR_I;
                m_wdata <= ref_data(bus.RWD_I, bus.Funct3, bus.Is_Load, bus.Addr_Lo);
                m_pc    <= bus.PC_I;
            end
        end
    end

    always @(negedge clk) begin
        check("done_o",   {31'd0, bus.Done_O},           {31'd0, m_done});
        check("rf_wen",   {31'd0, bus.RF_wen},           {31'd0, m_wen});
        check("busy",     {31'd0, bus.Feedback_WB_Busy}, {31'd0, m_wen});
        check("rf_waddr", {27'd0, bus.RF_waddr},         {27'd0, m_waddr});
        check("rf_wdata", bus.RF_wdata,                  m_wdata);
        check("pc_o",     bus.PC_O,                      m_pc);
    end

    task automatic put(input logic [31:0] pc, input logic [31:0] rwd, input logic [4:0] rd,
                       input logic [2:0] f3, input logic ld, input logic [1:0] lo);
        bus.Done_I = 1'b1; bus.PC_I = pc; bus.RWD_I = rwd; bus.RAR_I = rd;
        bus.Funct3 = f3; bus.Is_Load = ld; bus.Addr_Lo = lo;
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        bus.Done_I = 1'b0;
        bus.PC_I = $urandom; bus.RWD_I = $urandom; bus.RAR_I = 5'($urandom);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        bus.Done_I = 1'b0; bus.PC_I = 32'd0; bus.RWD_I = 32'd0; bus.RAR_I = 5'd0;
        bus.Funct3 = 3'd0; bus.Is_Load = 1'b0; bus.Addr_Lo = 2'd0;
        repeat (3) @(negedge clk);
        check("reset_wen",   {31'd0, bus.RF_wen}, 32'd0);
        check("reset_pc",    bus.PC_O,            32'd0);
        check("reset_wdata", bus.RF_wdata,        32'd0);

        // Done_I present on the first edge after release is dropped.
        rst = 1'b1;
        put(32'h40, 32'hDEAD_BEEF, 5'd7, 3'd0, 1'b0, 2'd0);
        check("release_done", {31'd0, bus.Done_O}, 32'd0);
        check("release_wen",  {31'd0, bus.RF_wen}, 32'd0);
        idle(2);

        put(32'h100, 32'h1234_5678, 5'd5, 3'b000, 1'b0, 2'd0);
        check("alu_done",  {31'd0, bus.Done_O}, 32'd1);
        check("alu_wen",   {31'd0, bus.RF_wen}, 32'd1);
        check("alu_waddr", {27'd0, bus.RF_waddr}, 32'd5);
        check("alu_wdata", bus.RF_wdata, 32'h1234_5678);
        check("alu_pc",    bus.PC_O, 32'h100);
        put(32'h104, 32'h80FF_00AA, 5'd6, 3'b000, 1'b1, 2'd3);
        check("lb_wdata",  bus.RF_wdata, 32'hFFFF_FF80);
        check("lb_done",   {31'd0, bus.Done_O}, 32'd1);
        put(32'h108, 32'h80FF_00AA, 5'd6, 3'b100, 1'b1, 2'd3);
        check("lbu_wdata", bus.RF_wdata, 32'h0000_0080);
        put(32'h10C, 32'h80FF_00AA, 5'd6, 3'b101, 1'b1, 2'd2);
        check("lhu_wdata", bus.RF_wdata, 32'h0000_80FF);
        put(32'h110, 32'h80FF_00AA, 5'd6, 3'b001, 1'b1, 2'd3);
        check("lh_mis",    bus.RF_wdata, 32'hFFFF_80FF);
        put(32'h114, 32'h80FF_00AA, 5'd6, 3'b010, 1'b1, 2'd1);
        check("lw_mis",    bus.RF_wdata, 32'h80FF_00AA);
        put(32'h118, 32'h80FF_00AA, 5'd6, 3'b111, 1'b1, 2'd1);
        check("rsv_f3",    bus.RF_wdata, 32'h80FF_00AA);
        put(32'h11C, 32'hCAFE_0001, 5'd0, 3'b000, 1'b0, 2'd0);
        check("x0_done",   {31'd0, bus.Done_O}, 32'd1);
        check("x0_wen",    {31'd0, bus.RF_wen}, 32'd0);
        idle(1);
        check("idle_done", {31'd0, bus.Done_O}, 32'd0);
        check("hold_pc",   bus.PC_O, 32'h11C);

        // Asynchronous reset while a write is pending.
        put(32'h200, 32'h5555_AAAA, 5'd9, 3'b000, 1'b0, 2'd0);
        check("pre_rst_wen", {31'd0, bus.RF_wen}, 32'd1);
        #2 rst = 1'b0;
        #1;
        check("mid_rst_wen",  {31'd0, bus.RF_wen}, 32'd0);
        check("mid_rst_done", {31'd0, bus.Done_O}, 32'd0);
        check("mid_rst_pc",   bus.PC_O, 32'd0);
        @(negedge clk);
        check("rst_edge_wen", {31'd0, bus.RF_wen}, 32'd0);
        rst = 1'b1;
        idle(3);

        for (int i = 0; i < 400; i++) begin
            bus.Done_I  = ($urandom_range(0, 9) < 7);
            bus.PC_I    = $urandom;
            bus.RWD_I   = $urandom;
            bus.RAR_I   = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom);
            bus.Funct3  = 3'($urandom);
            bus.Is_Load = 1'($urandom);
            bus.Addr_Lo = 2'($urandom);
            @(negedge clk);
        end
        idle(2);

`ifdef PERF_CNT_EN
        force dut.r_cycle_cnt = 32'hFFFF_FFFF;
        #1 release dut.r_cycle_cnt;
        @(posedge clk); #1;
        check("cycle_wrap", bus.Cycle_Cnt, 32'h0000_0000);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
`default_nettype wire
